// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding,
// nibble slice width and the helper that derives the nibble count.
package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  // Number of nibble cycles needed to cover a width-bit operand.
  function automatic int nslice_of(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/ripple_adder.sv
// 4-bit ripple-carry adder slice, purely combinational.
module ripple_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] carry_s;

  // Bit-by-bit ripple of the carry through the four full adders.
  always_comb begin
    carry_s    = 5'b0_0000;
    sum_o      = 4'b0000;
    carry_s[0] = cin_i;
    for (int i = 0; i < 4; i++) begin
      sum_o[i]       = a_i[i] ^ b_i[i] ^ carry_s[i];
      carry_s[i + 1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry_s[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder built around one 4-bit ripple slice.
// One nibble is processed per clock, LSB first; a registered carry links
// consecutive nibbles. Valid/ready handshakes on input and output.
// Optional two's-complement overflow output enabled by the macro
// NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = nslice_of(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  // Slice results form the next value of the current result nibble.
  logic [SLICE_W-1:0] slice_sum_d;
  logic               slice_cout_d;

  ripple_adder u_slice (
    .a_i    (a_q[idx_q * SLICE_W +: SLICE_W]),
    .b_i    (b_q[idx_q * SLICE_W +: SLICE_W]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum_d),
    .cout_o (slice_cout_d)
  );

  // Control FSM plus operand, carry, result and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            idx_q      <= '0;
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          sum_q[idx_q * SLICE_W +: SLICE_W] <= slice_sum_d;
          carry_q <= slice_cout_d;
          idx_q   <= idx_q + IDX_ONE;
          if (idx_q == LAST_IDX) begin
            idx_q       <= '0;
            cout_q      <= slice_cout_d;
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            // Same-sign operands whose result sign differs have overflowed.
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (slice_sum_d[SLICE_W-1] != a_q[WIDTH-1]);
`endif
          end
        end
        ST_DONE: begin
          // Result holds until the consumer takes it; sum is not cleared.
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          idx_q       <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
